// File: rtl/input_arbiter.sv
// Merges board-button, NES-controller and UART-byte events into one ordered
// command stream: sticky per-class pending state, round-robin grant, small FIFO.
module input_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               io_btn,
    input  logic [7:0]               io_nes,
    input  logic                     io_nesEnable,
    input  logic                     io_rx_valid,
    input  logic [7:0]               io_rx_bits,
    output logic                     io_cmd_valid,
    input  logic                     io_cmd_ready,
    output logic [9:0]               io_cmd_bits,
    output logic [7:0]               io_overrun,
    output logic [$clog2(DEPTH):0]   io_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] SRC_BTN  = 2'd0;
    localparam logic [1:0] SRC_NES  = 2'd1;
    localparam logic [1:0] SRC_UART = 2'd2;

    logic [1:0]  r_btn_pend;
    logic [7:0]  r_nes_pend;
    logic        r_uart_pend;
    logic [7:0]  r_uart_byte;
    logic [7:0]  r_overrun;
    logic [1:0]  r_last;
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [9:0]  r_mem [DEPTH];

    logic        w_req_btn, w_req_nes, w_req_uart;
    logic        w_gnt_btn, w_gnt_nes, w_gnt_uart;
    logic        w_push, w_pop, w_valid, w_full;
    logic [AW:0] w_count;
    logic [9:0]  w_push_data;

    assign w_req_btn  = |r_btn_pend;
    assign w_req_nes  = |r_nes_pend;
    assign w_req_uart = r_uart_pend;

    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & io_cmd_ready;

    // Round-robin: search begins at the class after the last one granted.
    always_comb begin
        w_gnt_btn  = 1'b0;
        w_gnt_nes  = 1'b0;
        w_gnt_uart = 1'b0;
        if (!w_full) begin
            case (r_last)
                SRC_BTN: begin
                    if (w_req_nes)       w_gnt_nes  = 1'b1;
                    else if (w_req_uart) w_gnt_uart = 1'b1;
                    else if (w_req_btn)  w_gnt_btn  = 1'b1;
                end
                SRC_NES: begin
                    if (w_req_uart)      w_gnt_uart = 1'b1;
                    else if (w_req_btn)  w_gnt_btn  = 1'b1;
                    else if (w_req_nes)  w_gnt_nes  = 1'b1;
                end
                default: begin
                    if (w_req_btn)       w_gnt_btn  = 1'b1;
                    else if (w_req_nes)  w_gnt_nes  = 1'b1;
                    else if (w_req_uart) w_gnt_uart = 1'b1;
                end
            endcase
        end
    end

    assign w_push = w_gnt_btn | w_gnt_nes | w_gnt_uart;

    always_comb begin
        if (w_gnt_btn)      w_push_data = {SRC_BTN, 6'b0, r_btn_pend};
        else if (w_gnt_nes) w_push_data = {SRC_NES, r_nes_pend};
        else                w_push_data = {SRC_UART, r_uart_byte};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_btn_pend  <= '0;
            r_nes_pend  <= '0;
            r_uart_pend <= 1'b0;
            r_overrun   <= '0;
            r_last      <= SRC_UART;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_btn_pend <= (w_gnt_btn ? 2'b0 : r_btn_pend) | io_btn;
            if (!io_nesEnable) r_nes_pend <= '0;
            else               r_nes_pend <= (w_gnt_nes ? 8'b0 : r_nes_pend) | io_nes;

            // A strobe in the UART grant cycle is a fresh byte, not an overrun.
            if (io_rx_valid) begin
                r_uart_pend <= 1'b1;
                if (r_uart_pend && !w_gnt_uart && r_overrun != 8'hFF)
                    r_overrun <= r_overrun + 8'd1;
            end else if (w_gnt_uart) begin
                r_uart_pend <= 1'b0;
            end

            if (w_gnt_btn)       r_last <= SRC_BTN;
            else if (w_gnt_nes)  r_last <= SRC_NES;
            else if (w_gnt_uart) r_last <= SRC_UART;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (io_rx_valid) r_uart_byte <= io_rx_bits;
        if (w_push)      r_mem[r_wptr[AW-1:0]] <= w_push_data;
    end

    assign io_cmd_valid = w_valid;
    assign io_cmd_bits  = w_valid ? r_mem[r_rptr[AW-1:0]] : 10'd0;
    assign io_overrun   = r_overrun;
    assign io_count     = w_count;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter: latency, ordering, backpressure, overrun,
// NES gating and asynchronous reset, with hand-computed expectations.
module tb_input_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] io_btn;
    logic [7:0] io_nes;
    logic       io_nesEnable;
    logic       io_rx_valid;
    logic [7:0] io_rx_bits;
    logic       io_cmd_valid;
    logic       io_cmd_ready;
    logic [9:0] io_cmd_bits;
    logic [7:0] io_overrun;
    logic [2:0] io_count;

    int n_pass  = 0;
    int n_total = 0;

    input_arbiter #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_btn       (io_btn),
        .io_nes       (io_nes),
        .io_nesEnable (io_nesEnable),
        .io_rx_valid  (io_rx_valid),
        .io_rx_bits   (io_rx_bits),
        .io_cmd_valid (io_cmd_valid),
        .io_cmd_ready (io_cmd_ready),
        .io_cmd_bits  (io_cmd_bits),
        .io_overrun   (io_overrun),
        .io_count     (io_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_uart();
        for (int i = 0; i < 4; i++) begin
            io_rx_valid = 1'b1;
            io_rx_bits  = 8'hA0 + 8'(i);
            tick();
        end
        io_rx_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", io_cmd_valid); else n_pass++;
        n_total++; if (io_cmd_bits !== 10'h000) $display("FAIL reset_bits got %h want 000", io_cmd_bits); else n_pass++;
        n_total++; if (io_overrun !== 8'd0) $display("FAIL reset_overrun got %0d want 0", io_overrun); else n_pass++;
        n_total++; if (io_count !== 3'd0) $display("FAIL reset_count got %0d want 0", io_count); else n_pass++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        io_cmd_ready = 1'b1;
        io_btn = 2'b01;
        tick();
        io_btn = 2'b00;
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL single_early got %b want 0", io_cmd_valid); else n_pass++;
        tick();
        n_total++; if (io_cmd_valid !== 1'b1) $display("FAIL single_valid got %b want 1", io_cmd_valid); else n_pass++;
        n_total++; if (io_cmd_bits !== 10'h001) $display("FAIL single_bits got %h want 001", io_cmd_bits); else n_pass++;
        n_total++; if (io_count !== 3'd1) $display("FAIL single_count got %0d want 1", io_count); else n_pass++;
        tick();
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL single_after got %b want 0", io_cmd_valid); else n_pass++;
        n_total++; if (io_count !== 3'd0) $display("FAIL single_count0 got %0d want 0", io_count); else n_pass++;
    endtask

    task automatic test_contention();
        logic [9:0] exp_q [3];
        exp_q[0] = 10'h002; exp_q[1] = 10'h101; exp_q[2] = 10'h241;
        do_reset();
        io_cmd_ready = 1'b1;
        io_nesEnable = 1'b1;
        io_btn = 2'b10; io_nes = 8'h01; io_rx_valid = 1'b1; io_rx_bits = 8'h41;
        tick();
        io_btn = 2'b00; io_nes = 8'h00; io_rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (io_cmd_valid !== 1'b1 || io_cmd_bits !== exp_q[i])
                $display("FAIL contention_%0d got valid=%b bits=%h want valid=1 bits=%h", i, io_cmd_valid, io_cmd_bits, exp_q[i]);
            else n_pass++;
        end
        tick();
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL contention_end got %b want 0", io_cmd_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_q [5];
        exp_q[0] = 10'h2A0; exp_q[1] = 10'h2A1; exp_q[2] = 10'h2A2;
        exp_q[3] = 10'h2A3; exp_q[4] = 10'h109;
        do_reset();
        io_cmd_ready = 1'b0;
        io_nesEnable = 1'b1;
        fill_uart();
        n_total++; if (io_count !== 3'd4) $display("FAIL bp_full got %0d want 4", io_count); else n_pass++;
        io_nes = 8'h01;
        tick();
        io_nes = 8'h00;
        repeat (4) tick();
        io_nes = 8'h08;
        tick();
        io_nes = 8'h00;
        repeat (2) tick();
        n_total++; if (io_count !== 3'd4) $display("FAIL bp_stall got %0d want 4", io_count); else n_pass++;
        n_total++; if (io_cmd_bits !== 10'h2A0) $display("FAIL bp_head_hold got %h want 2A0", io_cmd_bits); else n_pass++;
        io_cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (io_cmd_valid !== 1'b1 || io_cmd_bits !== exp_q[i])
                $display("FAIL bp_drain_%0d got valid=%b bits=%h want valid=1 bits=%h", i, io_cmd_valid, io_cmd_bits, exp_q[i]);
            else n_pass++;
            tick();
        end
        n_total++; if (io_count !== 3'd0) $display("FAIL bp_empty got %0d want 0", io_count); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [9:0] exp_q [5];
        exp_q[0] = 10'h2A0; exp_q[1] = 10'h2A1; exp_q[2] = 10'h2A2;
        exp_q[3] = 10'h2A3; exp_q[4] = 10'h220;
        do_reset();
        io_cmd_ready = 1'b0;
        fill_uart();
        io_rx_valid = 1'b1; io_rx_bits = 8'h10;
        tick();
        n_total++; if (io_overrun !== 8'd0) $display("FAIL ovr_first got %0d want 0", io_overrun); else n_pass++;
        io_rx_bits = 8'h20;
        tick();
        io_rx_valid = 1'b0;
        n_total++; if (io_overrun !== 8'd1) $display("FAIL ovr_count got %0d want 1", io_overrun); else n_pass++;
        io_cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (io_cmd_valid !== 1'b1 || io_cmd_bits !== exp_q[i])
                $display("FAIL ovr_drain_%0d got valid=%b bits=%h want valid=1 bits=%h", i, io_cmd_valid, io_cmd_bits, exp_q[i]);
            else n_pass++;
            tick();
        end
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL ovr_end got %b want 0", io_cmd_valid); else n_pass++;
    endtask

    task automatic test_overrun_sat();
        do_reset();
        io_cmd_ready = 1'b0;
        fill_uart();
        io_rx_valid = 1'b1; io_rx_bits = 8'h55;
        repeat (300) tick();
        io_rx_valid = 1'b0;
        n_total++; if (io_overrun !== 8'd255) $display("FAIL ovr_sat got %0d want 255", io_overrun); else n_pass++;
        do_reset();
        n_total++; if (io_overrun !== 8'd0) $display("FAIL ovr_reset got %0d want 0", io_overrun); else n_pass++;
    endtask

    task automatic test_nes_gating();
        do_reset();
        io_cmd_ready = 1'b1;
        io_nesEnable = 1'b0;
        io_nes = 8'hFF;
        tick();
        io_nes = 8'h00;
        repeat (3) tick();
        n_total++; if (io_count !== 3'd0) $display("FAIL gate_count got %0d want 0", io_count); else n_pass++;
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL gate_valid got %b want 0", io_cmd_valid); else n_pass++;
        io_nesEnable = 1'b1;
        io_nes = 8'h80;
        tick();
        io_nes = 8'h00;
        tick();
        n_total++; if (io_cmd_valid !== 1'b1 || io_cmd_bits !== 10'h180)
            $display("FAIL gate_enabled got valid=%b bits=%h want valid=1 bits=180", io_cmd_valid, io_cmd_bits);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        io_cmd_ready = 1'b0;
        io_btn = 2'b01;
        repeat (3) tick();
        io_btn = 2'b00;
        repeat (2) tick();
        n_total++; if (io_count !== 3'd3) $display("FAIL ar_count3 got %0d want 3", io_count); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", io_cmd_valid); else n_pass++;
        n_total++; if (io_count !== 3'd0) $display("FAIL ar_count got %0d want 0", io_count); else n_pass++;
        reset = 1'b0;
        io_btn = 2'b01;
        tick();
        io_btn = 2'b00;
        n_total++; if (io_cmd_valid !== 1'b0) $display("FAIL ar_early got %b want 0", io_cmd_valid); else n_pass++;
        tick();
        n_total++; if (io_cmd_valid !== 1'b1 || io_cmd_bits !== 10'h001)
            $display("FAIL ar_after got valid=%b bits=%h want valid=1 bits=001", io_cmd_valid, io_cmd_bits);
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        io_btn       = 2'b00;
        io_nes       = 8'h00;
        io_nesEnable = 1'b1;
        io_rx_valid  = 1'b0;
        io_rx_bits   = 8'h00;
        io_cmd_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overrun();
        test_overrun_sat();
        test_nes_gating();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
